// File: rtl/cla_slice_sequencer.sv
// Multi-cycle WIDTH-bit add/subtract unit that reuses one 8-bit carry-lookahead
// slice, least-significant slice first, behind valid/ready handshakes.

module eight_bit_cla (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] s,
    output logic [8:0] c,
    output logic       g_grp,
    output logic       p_grp
);
    logic [7:0] g;
    logic [7:0] p;
    logic       pp;

    assign g = a & b;
    assign p = a ^ b;

    // Each carry is a flat sum of products over generate/propagate terms.
    always_comb begin
        c     = '0;
        c[0]  = cin;
        pp    = 1'b0;
        for (int i = 0; i < 8; i++) begin
            c[i+1] = g[i];
            pp     = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                c[i+1] = c[i+1] | (pp & g[j]);
                pp     = pp & p[j];
            end
            c[i+1] = c[i+1] | (pp & cin);
        end
    end

    always_comb begin
        g_grp = g[7];
        p_grp = p[7];
        for (int j = 6; j >= 0; j--) begin
            g_grp = g_grp | (p_grp & g[j]);
            p_grp = p_grp & p[j];
        end
    end

    assign s = p ^ c[7:0];
endmodule

module cla_slice_sequencer #(
    parameter int WIDTH  = 32,
    parameter int SLICES = WIDTH / 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             busy
);
    localparam int IDX_W = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLICES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic [7:0] sl_a, sl_b, sl_s;
    logic [8:0] sl_c;
    logic       sl_g, sl_p;

    assign sl_a = a_q[idx_q*8 +: 8];
    assign sl_b = b_q[idx_q*8 +: 8];

    eight_bit_cla u_cla (
        .a    (sl_a),
        .b    (sl_b),
        .cin  (carry_q),
        .s    (sl_s),
        .c    (sl_c),
        .g_grp(sl_g),
        .p_grp(sl_p)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a_in;
                    b_d     = op_sub ? ~b_in : b_in;
                    carry_d = op_sub;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                result_d[idx_q*8 +: 8] = sl_s;
                carry_d = sl_g | (sl_p & carry_q);
                idx_d   = idx_q + 1'b1;
                // Zero flag sees the slice being written this cycle.
                if (idx_q == LAST_IDX) begin
                    cout_d  = carry_d;
                    ovf_d   = sl_c[7] ^ carry_d;
                    zero_d  = (result_d == '0);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == RUN);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;
endmodule

// File: tb/tb_cla_slice_sequencer.sv
// Directed bench for cla_slice_sequencer: arithmetic corners, latency,
// backpressure and mid-operation reset.

module tb_cla_slice_sequencer;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        op_sub = 1'b0;
    logic [31:0] a_in = '0;
    logic [31:0] b_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        cout, ovf, zero, busy;

    int checks = 0;
    int errors = 0;

    cla_slice_sequencer #(.WIDTH(32)) dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .op_sub(op_sub), .a_in(a_in), .b_in(b_in), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .cout(cout), .ovf(ovf),
        .zero(zero), .busy(busy)
    );

    always #5 clock = ~clock;

    // Drives one request and waits for out_valid; lat = edges after accept, -1 on timeout.
    task automatic run_op(input logic sub, input logic [31:0] a, input logic [31:0] b,
                          output int lat);
        int n;
        lat = -1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clock); #1; n++;
        end
        op_sub = sub; a_in = a; b_in = b; in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        a_in = 32'hDEAD_BEEF; b_in = 32'hCAFE_F00D; op_sub = ~sub;
        for (int i = 1; i <= 20; i++) begin
            if (out_valid) break;
            @(posedge clock); #1;
            if (out_valid) begin lat = i; break; end
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: in_ready=%b out_valid=%b busy=%b, want 1 0 0", in_ready, out_valid, busy);
        end
        checks++;
        if (result !== 32'h0 || cout !== 1'b0 || ovf !== 1'b0 || zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_data: result=%h c=%b v=%b z=%b, want 0", result, cout, ovf, zero);
        end
    endtask

    task automatic test_add();
        int lat;
        run_op(1'b0, 32'h0000_00FF, 32'h0000_0001, lat);
        checks++;
        if (lat !== 4) begin errors++; $display("FAIL add_latency: got %0d want 4", lat); end
        checks++;
        if ({result, cout, ovf, zero} !== {32'h0000_0100, 3'b000}) begin
            errors++; $display("FAIL add_ff_1: got %h c%b v%b z%b want 00000100 c0 v0 z0", result, cout, ovf, zero);
        end
        release_out();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL add_release: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
        run_op(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, lat);
        checks++;
        if ({result, cout, ovf, zero} !== {32'h0, 3'b101}) begin
            errors++; $display("FAIL add_wrap: got %h c%b v%b z%b want 00000000 c1 v0 z1", result, cout, ovf, zero);
        end
        release_out();
        run_op(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, lat);
        checks++;
        if ({result, cout, ovf, zero} !== {32'h8000_0000, 3'b010}) begin
            errors++; $display("FAIL add_ovf: got %h c%b v%b z%b want 80000000 c0 v1 z0", result, cout, ovf, zero);
        end
        release_out();
    endtask

    task automatic test_sub();
        int lat;
        run_op(1'b1, 32'h8000_0000, 32'h0000_0001, lat);
        checks++;
        if ({result, cout, ovf, zero} !== {32'h7FFF_FFFF, 3'b110}) begin
            errors++; $display("FAIL sub_ovf: got %h c%b v%b z%b want 7fffffff c1 v1 z0", result, cout, ovf, zero);
        end
        release_out();
        run_op(1'b1, 32'h0000_0005, 32'h0000_0007, lat);
        checks++;
        if ({result, cout, ovf, zero} !== {32'hFFFF_FFFE, 3'b000}) begin
            errors++; $display("FAIL sub_borrow: got %h c%b v%b z%b want fffffffe c0 v0 z0", result, cout, ovf, zero);
        end
        release_out();
        run_op(1'b1, 32'h0000_0005, 32'h0000_0005, lat);
        checks++;
        if ({result, cout, ovf, zero} !== {32'h0, 3'b101}) begin
            errors++; $display("FAIL sub_zero: got %h c%b v%b z%b want 00000000 c1 v0 z1", result, cout, ovf, zero);
        end
        release_out();
    endtask

    task automatic test_back_to_back();
        int lat;
        int bad;
        run_op(1'b0, 32'h0001_0000, 32'h0000_FFFF, lat);
        checks++;
        if (result !== 32'h0001_FFFF || out_valid !== 1'b1) begin
            errors++; $display("FAIL bp_first: got %h valid=%b want 0001ffff 1", result, out_valid);
        end
        op_sub = 1'b0; a_in = 32'h1234_5678; b_in = 32'h1111_1111; in_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            if (result !== 32'h0001_FFFF || out_valid !== 1'b1 || in_ready !== 1'b0 ||
                busy !== 1'b0 || cout !== 1'b0 || ovf !== 1'b0 || zero !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL bp_hold: %0d unstable cycles, want 0", bad);
        end
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_idle: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
        @(posedge clock); #1;
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_accept: busy=%b in_ready=%b want 1 0", busy, in_ready);
        end
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clock); #1;
            if (out_valid) begin lat = i; break; end
        end
        checks++;
        if (lat !== 4 || result !== 32'h2345_6789) begin
            errors++; $display("FAIL bp_pending: lat=%0d result=%h want 4 23456789", lat, result);
        end
        release_out();
    endtask

    task automatic test_mid_reset();
        int lat;
        op_sub = 1'b1; a_in = 32'h0000_00FF; b_in = 32'h0000_0000; in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || result !== 32'h0 ||
            cout !== 1'b0 || ovf !== 1'b0 || zero !== 1'b0) begin
            errors++; $display("FAIL mid_reset: rdy=%b vld=%b busy=%b res=%h c%b v%b z%b want reset values",
                               in_ready, out_valid, busy, result, cout, ovf, zero);
        end
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock); #1;
        run_op(1'b0, 32'h0000_0001, 32'h0000_0001, lat);
        checks++;
        if (lat !== 4 || {result, cout, ovf, zero} !== {32'h2, 3'b000}) begin
            errors++; $display("FAIL post_reset: lat=%0d got %h c%b v%b z%b want 4 00000002 c0 v0 z0",
                               lat, result, cout, ovf, zero);
        end
        release_out();
    endtask

    initial begin
        #12;
        test_reset();
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock); #1;
        test_reset();
        test_add();
        test_sub();
        test_back_to_back();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, limit 200000");
        $fatal(1);
    end
endmodule
